// File: rtl/mesh_barrier_ctrl.sv
// Root barrier scheduler for the mesh synchronization network.
// Each barrier collects arrivals from its member tiles, releases them together
// (or on timeout with error), and every tile is answered over a wake/ack handshake.
module mesh_barrier_ctrl #(
  parameter int N_TILES    = 4,
  parameter int N_BARRIERS = 2,
  parameter int TIMEOUT_W  = 16,
  parameter int BAR_W      = (N_BARRIERS > 1) ? $clog2(N_BARRIERS) : 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       cfg_we_i,
  input  logic [BAR_W-1:0]           cfg_bar_i,
  input  logic [N_TILES-1:0]         cfg_mask_i,
  input  logic [TIMEOUT_W-1:0]       cfg_timeout_i,
  output logic                       cfg_err_o,
  input  logic [N_TILES-1:0]         sync_req_i,
  input  logic [N_TILES*BAR_W-1:0]   sync_bar_i,
  output logic [N_TILES-1:0]         sync_wake_o,
  output logic [N_TILES-1:0]         sync_error_o,
  input  logic [N_TILES-1:0]         sync_ack_i,
  output logic [N_BARRIERS-1:0]      bar_busy_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_RELEASE = 2'd2
  } state_e;

  state_e               state_q   [N_BARRIERS];
  state_e               state_d   [N_BARRIERS];
  logic [N_TILES-1:0]   mask_q    [N_BARRIERS];
  logic [N_TILES-1:0]   mask_d    [N_BARRIERS];
  logic [TIMEOUT_W-1:0] timeout_q [N_BARRIERS];
  logic [TIMEOUT_W-1:0] timeout_d [N_BARRIERS];
  logic [TIMEOUT_W-1:0] cnt_q     [N_BARRIERS];
  logic [TIMEOUT_W-1:0] cnt_d     [N_BARRIERS];
  logic [N_TILES-1:0]   arrived_q [N_BARRIERS];
  logic [N_TILES-1:0]   arrived_d [N_BARRIERS];
  logic [N_TILES-1:0]   new_arr   [N_BARRIERS];

  logic [N_TILES-1:0]    wake_q, wake_d;
  logic [N_TILES-1:0]    error_q, error_d;
  logic                  cfg_err_q, cfg_err_d;
  logic [N_BARRIERS-1:0] busy_q, busy_d;

  logic [N_TILES-1:0]    tile_busy;
  logic [N_TILES-1:0]    tile_ok;
  logic [N_TILES-1:0]    ack_eff;
  logic [N_BARRIERS-1:0] expire;
  logic                  cfg_ok;

  // Next-state logic: ack handling, arrival steering, per-barrier FSMs, config writes
  always_comb begin
    wake_d    = wake_q;
    error_d   = error_q;
    cfg_err_d = 1'b0;
    cfg_ok    = 1'b0;
    ack_eff   = sync_ack_i & wake_q;
    tile_busy = wake_q;
    tile_ok   = '0;
    expire    = '0;
    for (int b = 0; b < N_BARRIERS; b++) begin
      state_d[b]   = state_q[b];
      mask_d[b]    = mask_q[b];
      timeout_d[b] = timeout_q[b];
      cnt_d[b]     = cnt_q[b];
      arrived_d[b] = arrived_q[b];
      new_arr[b]   = '0;
      tile_busy    = tile_busy | arrived_q[b];
    end

    // An ack only counts while the tile is actually being woken
    wake_d  = wake_d & ~ack_eff;
    error_d = error_d & ~ack_eff;

    // Steer each fresh request to its barrier, or answer it with an error wake
    for (int i = 0; i < N_TILES; i++) begin
      if (sync_req_i[i] && !tile_busy[i]) begin
        for (int b = 0; b < N_BARRIERS; b++) begin
          if (sync_bar_i[i*BAR_W +: BAR_W] == BAR_W'(b) &&
              mask_q[b][i] && state_q[b] != S_RELEASE) begin
            new_arr[b][i] = 1'b1;
            tile_ok[i]    = 1'b1;
          end
        end
        if (!tile_ok[i]) begin
          wake_d[i]  = 1'b1;
          error_d[i] = 1'b1;
        end
      end
    end

    // Barrier FSMs; completion is checked before expiry so it wins a tie
    for (int b = 0; b < N_BARRIERS; b++) begin
      expire[b] = (timeout_q[b] != '0) &&
                  (cnt_q[b] == timeout_q[b] - TIMEOUT_W'(1));
      case (state_q[b])
        S_IDLE: begin
          if (new_arr[b] != '0) begin
            arrived_d[b] = new_arr[b];
            cnt_d[b]     = '0;
            if (new_arr[b] == mask_q[b]) begin
              state_d[b] = S_RELEASE;
              wake_d     = wake_d | new_arr[b];
              error_d    = error_d & ~new_arr[b];
            end else begin
              state_d[b] = S_COLLECT;
            end
          end
        end
        S_COLLECT: begin
          arrived_d[b] = arrived_q[b] | new_arr[b];
          cnt_d[b]     = cnt_q[b] + TIMEOUT_W'(1);
          if (arrived_d[b] == mask_q[b]) begin
            state_d[b] = S_RELEASE;
            wake_d     = wake_d | arrived_d[b];
            error_d    = error_d & ~arrived_d[b];
          end else if (expire[b]) begin
            state_d[b] = S_RELEASE;
            wake_d     = wake_d | arrived_d[b];
            error_d    = error_d | arrived_d[b];
          end
        end
        S_RELEASE: begin
          arrived_d[b] = arrived_q[b] & ~ack_eff;
          if (arrived_d[b] == '0) begin
            state_d[b] = S_IDLE;
          end
        end
        default: begin
          state_d[b] = S_IDLE;
        end
      endcase
    end

    // Configuration only lands on an idle, existing barrier
    if (cfg_we_i) begin
      for (int b = 0; b < N_BARRIERS; b++) begin
        if (cfg_bar_i == BAR_W'(b) && state_q[b] == S_IDLE) begin
          mask_d[b]    = cfg_mask_i;
          timeout_d[b] = cfg_timeout_i;
          cfg_ok       = 1'b1;
        end
      end
      cfg_err_d = !cfg_ok;
    end

    for (int b = 0; b < N_BARRIERS; b++) begin
      busy_d[b] = (state_d[b] != S_IDLE);
    end
  end

  // State registers; reset aborts every barrier without waking anyone
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int b = 0; b < N_BARRIERS; b++) begin
        state_q[b]   <= S_IDLE;
        mask_q[b]    <= '0;
        timeout_q[b] <= '0;
        cnt_q[b]     <= '0;
        arrived_q[b] <= '0;
      end
      mask_q[0] <= '1;
      wake_q    <= '0;
      error_q   <= '0;
      cfg_err_q <= 1'b0;
      busy_q    <= '0;
    end else begin
      for (int b = 0; b < N_BARRIERS; b++) begin
        state_q[b]   <= state_d[b];
        mask_q[b]    <= mask_d[b];
        timeout_q[b] <= timeout_d[b];
        cnt_q[b]     <= cnt_d[b];
        arrived_q[b] <= arrived_d[b];
      end
      wake_q    <= wake_d;
      error_q   <= error_d;
      cfg_err_q <= cfg_err_d;
      busy_q    <= busy_d;
    end
  end

  assign sync_wake_o  = wake_q;
  assign sync_error_o = error_q;
  assign cfg_err_o    = cfg_err_q;
  assign bar_busy_o   = busy_q;

endmodule

// File: tb/tb_mesh_barrier_ctrl.sv
// Directed bench for mesh_barrier_ctrl with 4 tiles and 2 barriers.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_mesh_barrier_ctrl;

  logic        clk;
  logic        rst;
  logic        cfg_we;
  logic [0:0]  cfg_bar;
  logic [3:0]  cfg_mask;
  logic [15:0] cfg_timeout;
  logic        cfg_err;
  logic [3:0]  sync_req;
  logic [3:0]  sync_bar;
  logic [3:0]  sync_wake;
  logic [3:0]  sync_error;
  logic [3:0]  sync_ack;
  logic [1:0]  bar_busy;

  int checks = 0;
  int fails  = 0;

  mesh_barrier_ctrl #(
    .N_TILES(4),
    .N_BARRIERS(2),
    .TIMEOUT_W(16)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .cfg_we_i(cfg_we),
    .cfg_bar_i(cfg_bar),
    .cfg_mask_i(cfg_mask),
    .cfg_timeout_i(cfg_timeout),
    .cfg_err_o(cfg_err),
    .sync_req_i(sync_req),
    .sync_bar_i(sync_bar),
    .sync_wake_o(sync_wake),
    .sync_error_o(sync_error),
    .sync_ack_i(sync_ack),
    .bar_busy_o(bar_busy)
  );

  // Free-running 10ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] req, input logic [3:0] bar,
                               input logic [3:0] ack);
    sync_req = req;
    sync_bar = bar;
    sync_ack = ack;
  endtask

  task automatic writeConfig(input logic [0:0] bar, input logic [3:0] mask,
                             input logic [15:0] timeout);
    cfg_we      = 1'b1;
    cfg_bar     = bar;
    cfg_mask    = mask;
    cfg_timeout = timeout;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      fails++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Directed scenario sequence
  initial begin
    rst = 1'b1;
    cfg_we = 1'b0;
    cfg_bar = '0;
    cfg_mask = '0;
    cfg_timeout = '0;
    applyStimulus(4'b0000, 4'b0000, 4'b0000);
    repeat (3) tick();
    checkOutput("rst_wake", 32'(sync_wake), 32'h0);
    checkOutput("rst_error", 32'(sync_error), 32'h0);
    checkOutput("rst_busy", 32'(bar_busy), 32'h0);
    checkOutput("rst_cfg_err", 32'(cfg_err), 32'h0);
    rst = 1'b0;
    tick();

    $display("[TB] default barrier 0, staggered arrivals");
    applyStimulus(4'b0001, 4'b0000, 4'b0000);
    tick();
    checkOutput("b0_busy_first", 32'(bar_busy), 32'h1);
    checkOutput("b0_wake_first", 32'(sync_wake), 32'h0);
    tick();
    applyStimulus(4'b0011, 4'b0000, 4'b0000);
    tick();
    tick();
    applyStimulus(4'b0111, 4'b0000, 4'b0000);
    tick();
    checkOutput("b0_wake_three", 32'(sync_wake), 32'h0);
    applyStimulus(4'b1111, 4'b0000, 4'b0000);
    tick();
    checkOutput("b0_wake_all", 32'(sync_wake), 32'hF);
    checkOutput("b0_error_all", 32'(sync_error), 32'h0);
    checkOutput("b0_busy_rel", 32'(bar_busy), 32'h1);
    applyStimulus(4'b1110, 4'b0000, 4'b0001);
    tick();
    checkOutput("b0_ack0_wake", 32'(sync_wake), 32'hE);
    checkOutput("b0_ack0_busy", 32'(bar_busy), 32'h1);
    applyStimulus(4'b1000, 4'b0000, 4'b0110);
    tick();
    checkOutput("b0_ack12_wake", 32'(sync_wake), 32'h8);
    applyStimulus(4'b0000, 4'b0000, 4'b1000);
    tick();
    checkOutput("b0_ack3_wake", 32'(sync_wake), 32'h0);
    checkOutput("b0_ack3_busy", 32'(bar_busy), 32'h0);
    applyStimulus(4'b0000, 4'b0000, 4'b0000);

    $display("[TB] barrier 1 timeout expiry");
    writeConfig(1'b1, 4'b0011, 16'd8);
    checkOutput("cfg_b1_ok", 32'(cfg_err), 32'h0);
    applyStimulus(4'b0001, 4'b0011, 4'b0000);
    tick();
    checkOutput("to_busy_start", 32'(bar_busy), 32'h2);
    repeat (7) tick();
    checkOutput("to_wake_before", 32'(sync_wake), 32'h0);
    checkOutput("to_busy_before", 32'(bar_busy), 32'h2);
    tick();
    checkOutput("to_wake_expire", 32'(sync_wake), 32'h1);
    checkOutput("to_error_expire", 32'(sync_error), 32'h1);
    applyStimulus(4'b0010, 4'b0011, 4'b0001);
    tick();
    checkOutput("to_inv_rel_wake", 32'(sync_wake), 32'h2);
    checkOutput("to_inv_rel_error", 32'(sync_error), 32'h2);
    checkOutput("to_busy_done", 32'(bar_busy), 32'h0);
    applyStimulus(4'b0000, 4'b0011, 4'b0010);
    tick();
    checkOutput("to_wake_clear", 32'(sync_wake), 32'h0);
    applyStimulus(4'b0000, 4'b0000, 4'b0000);

    $display("[TB] completion in the expiry cycle");
    writeConfig(1'b1, 4'b0011, 16'd3);
    checkOutput("cfg_b1_ok2", 32'(cfg_err), 32'h0);
    applyStimulus(4'b0001, 4'b0011, 4'b0000);
    tick();
    tick();
    tick();
    checkOutput("tie_wake_before", 32'(sync_wake), 32'h0);
    applyStimulus(4'b0011, 4'b0011, 4'b0000);
    tick();
    checkOutput("tie_wake", 32'(sync_wake), 32'h3);
    checkOutput("tie_error", 32'(sync_error), 32'h0);
    applyStimulus(4'b0000, 4'b0011, 4'b0011);
    tick();
    checkOutput("tie_wake_clear", 32'(sync_wake), 32'h0);
    checkOutput("tie_busy_clear", 32'(bar_busy), 32'h0);
    applyStimulus(4'b0000, 4'b0000, 4'b0000);

    $display("[TB] non-member request");
    applyStimulus(4'b0100, 4'b0100, 4'b0000);
    tick();
    checkOutput("inv_wake", 32'(sync_wake), 32'h4);
    checkOutput("inv_error", 32'(sync_error), 32'h4);
    checkOutput("inv_busy", 32'(bar_busy), 32'h0);
    tick();
    checkOutput("inv_wake_hold", 32'(sync_wake), 32'h4);
    applyStimulus(4'b0000, 4'b0100, 4'b0100);
    tick();
    checkOutput("inv_wake_clear", 32'(sync_wake), 32'h0);
    checkOutput("inv_error_clear", 32'(sync_error), 32'h0);
    applyStimulus(4'b0000, 4'b0000, 4'b0000);

    $display("[TB] config write to a collecting barrier");
    applyStimulus(4'b0001, 4'b0000, 4'b0000);
    tick();
    checkOutput("rej_busy", 32'(bar_busy), 32'h1);
    writeConfig(1'b0, 4'b0001, 16'd0);
    checkOutput("rej_cfg_err", 32'(cfg_err), 32'h1);
    tick();
    checkOutput("rej_cfg_err_drop", 32'(cfg_err), 32'h0);
    checkOutput("rej_mask_kept", 32'(sync_wake), 32'h0);
    applyStimulus(4'b1111, 4'b0000, 4'b0000);
    tick();
    checkOutput("rej_wake_all", 32'(sync_wake), 32'hF);
    checkOutput("rej_error_all", 32'(sync_error), 32'h0);
    applyStimulus(4'b0000, 4'b0000, 4'b1111);
    tick();
    checkOutput("rej_wake_clear", 32'(sync_wake), 32'h0);
    checkOutput("rej_busy_clear", 32'(bar_busy), 32'h0);
    applyStimulus(4'b0000, 4'b0000, 4'b0000);

    $display("[TB] reset while collecting");
    applyStimulus(4'b0011, 4'b0000, 4'b0000);
    tick();
    checkOutput("mid_busy", 32'(bar_busy), 32'h1);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_busy", 32'(bar_busy), 32'h0);
    checkOutput("mid_rst_wake", 32'(sync_wake), 32'h0);
    checkOutput("mid_rst_cfg_err", 32'(cfg_err), 32'h0);
    applyStimulus(4'b0000, 4'b0000, 4'b0000);
    tick();
    rst = 1'b0;
    tick();
    applyStimulus(4'b1111, 4'b0000, 4'b0000);
    tick();
    checkOutput("post_wake", 32'(sync_wake), 32'hF);
    checkOutput("post_error", 32'(sync_error), 32'h0);
    checkOutput("post_busy", 32'(bar_busy), 32'h1);
    applyStimulus(4'b0000, 4'b0000, 4'b1111);
    tick();
    checkOutput("post_wake_clear", 32'(sync_wake), 32'h0);
    checkOutput("post_busy_clear", 32'(bar_busy), 32'h0);
    applyStimulus(4'b1000, 4'b1000, 4'b0000);
    tick();
    checkOutput("post_b1_mask0_wake", 32'(sync_wake), 32'h8);
    checkOutput("post_b1_mask0_error", 32'(sync_error), 32'h8);
    checkOutput("post_b1_busy", 32'(bar_busy), 32'h0);
    applyStimulus(4'b0000, 4'b1000, 4'b1000);
    tick();
    checkOutput("post_b1_clear", 32'(sync_wake), 32'h0);
    applyStimulus(4'b0000, 4'b0000, 4'b0000);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
